// File: rtl/acc_ctrl_seq_pkg.sv
// Shared types and constants for the accumulator decode/sequencing stage.
package acc_pkg;

  typedef enum logic [3:0] {
    OP_LD   = 4'h0,
    OP_ST   = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8,
    OP_LW   = 4'h9,
    OP_SW   = 4'hA,
    OP_NOP  = 4'hB,
    OP_ILLC = 4'hC,
    OP_ILLD = 4'hD,
    OP_ILLE = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_MEM_WAIT,
    S_HALTED,
    S_ERROR
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6
  } aluop_e;

  localparam logic [1:0] ACCSEL_ALU   = 2'd0;
  localparam logic [1:0] ACCSEL_RDATA = 2'd1;
  localparam logic [1:0] ACCSEL_MEM   = 2'd2;

  localparam logic [3:0] ACC_IDX = 4'b1110;

  localparam int unsigned OPC_MSB = 8;
  localparam int unsigned OPC_LSB = 5;
  localparam int unsigned R_BIT   = 4;

  // ALU opcodes are contiguous starting at ADD, so the ALU op is a plain offset.
  function automatic aluop_e opToAlu(input opcode_e op);
    logic [3:0] d;
    d = op - OP_ADD;
    return aluop_e'(d[2:0]);
  endfunction

endpackage

// File: rtl/acc_ctrl_seq_if.sv
// Fetch handshake and data-memory request bus of the decode/sequencing stage.
interface acc_ctrl_seq_if;
  logic       InstValid;
  logic [8:0] Inst;
  logic       InstReady;
  logic       MemReq;
  logic       MemWrite;
  logic       MemAck;

  modport master (
    output InstValid, Inst, MemAck,
    input  InstReady, MemReq, MemWrite
  );

  modport slave (
    input  InstValid, Inst, MemAck,
    output InstReady, MemReq, MemWrite
  );
endinterface

// File: rtl/acc_ctrl_seq_mem_wait_timer.sv
// Counts consecutive un-acknowledged memory-wait cycles; Expire flags the
// MEM_TIMEOUT-th such cycle combinationally.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic CLK,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic Expire
);
  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [CW-1:0] count;

  assign Expire = Enable && (count == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (Reset || Clear) begin
      count <= '0;
    end else if (Enable && !Expire) begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/acc_ctrl_seq.sv
// Decode/sequencing stage feeding the accumulator register file: decodes fetch
// instructions, sequences loads/stores with an ack timeout, counts retirements.
module acc_ctrl_seq #(
  parameter int unsigned RAW         = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [RAW-1:0] ACC_IDX  = RAW'(acc_pkg::ACC_IDX)
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic           Start,
  acc_ctrl_seq_if.slave  bus,
  output logic [RAW-1:0] ReadAddr,
  output logic           ReadRegEn,
  output logic [RAW-1:0] RegWriteAddr,
  output logic           WriteRegEn,
  output logic           WriteACCEn,
  output logic [1:0]     ACCSel,
  output logic [2:0]     ALUOp,
  output logic           Done,
  output logic           Error,
  output logic [15:0]    InstCount
);
  import acc_pkg::*;

  state_e         state, nextState;
  opcode_e        opc;
  logic           instR;
  logic [RAW-1:0] operand;
  logic           illegal;
  logic           retire;
  logic           memStart;
  logic           memIsStore;
  logic           memR;
  logic [RAW-1:0] memOperand;
  logic [15:0]    count;
  logic           timerEn, timerClear, timerExpire;

  assign opc     = opcode_e'(bus.Inst[OPC_MSB:OPC_LSB]);
  assign instR   = bus.Inst[R_BIT];
  assign operand = bus.Inst[RAW-1:0];
  assign illegal = (opc == OP_ILLC) || (opc == OP_ILLD) || (opc == OP_ILLE) ||
                   ((opc == OP_ST) && !instR);

  assign timerEn    = !Reset && (state == S_MEM_WAIT) && !bus.MemAck;
  assign timerClear = (state != S_MEM_WAIT) || bus.MemAck;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) waitTimer (
    .CLK    (CLK),
    .Reset  (Reset),
    .Clear  (timerClear),
    .Enable (timerEn),
    .Expire (timerExpire)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= S_IDLE;
      count      <= '0;
      memIsStore <= 1'b0;
      memR       <= 1'b0;
      memOperand <= '0;
    end else begin
      state <= nextState;
      if ((state == S_HALTED) && Start) begin
        count <= '0;
      end else if (retire && (count != '1)) begin
        count <= count + 16'd1;
      end
      if (memStart) begin
        memIsStore <= (opc == OP_SW);
        memR       <= instR;
        memOperand <= operand;
      end
    end
  end

  always_comb begin
    nextState     = state;
    bus.InstReady = 1'b0;
    bus.MemReq    = 1'b0;
    bus.MemWrite  = 1'b0;
    ReadAddr      = '0;
    ReadRegEn     = 1'b0;
    RegWriteAddr  = '0;
    WriteRegEn    = 1'b0;
    WriteACCEn    = 1'b0;
    ACCSel        = ACCSEL_ALU;
    ALUOp         = ALU_ADD;
    retire        = 1'b0;
    memStart      = 1'b0;
    if (!Reset) begin
      unique case (state)
        S_IDLE: if (Start) nextState = S_RUN;
        S_RUN: begin
          bus.InstReady = 1'b1;
          if (bus.InstValid) begin
            if (illegal) begin
              nextState = S_ERROR;
            end else begin
              ReadAddr     = operand;
              ReadRegEn    = instR;
              RegWriteAddr = operand;
              retire       = 1'b1;
              unique case (opc)
                OP_LD: begin
                  WriteACCEn = 1'b1;
                  ACCSel     = ACCSEL_RDATA;
                end
                // Storing ACC into its own slot is suppressed so it has no effect.
                OP_ST: WriteRegEn = (operand != ACC_IDX);
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                  WriteACCEn = 1'b1;
                  ALUOp      = opToAlu(opc);
                end
                OP_LW, OP_SW: begin
                  retire    = 1'b0;
                  memStart  = 1'b1;
                  nextState = S_MEM_WAIT;
                end
                OP_HALT: nextState = S_HALTED;
                default: ;
              endcase
            end
          end
        end
        S_MEM_WAIT: begin
          bus.MemReq   = 1'b1;
          bus.MemWrite = memIsStore;
          ReadAddr     = memOperand;
          ReadRegEn    = memR;
          if (bus.MemAck) begin
            if (!memIsStore) begin
              WriteACCEn = 1'b1;
              ACCSel     = ACCSEL_MEM;
            end
            retire    = 1'b1;
            nextState = S_RUN;
          end else if (timerExpire) begin
            nextState = S_ERROR;
          end
        end
        S_HALTED: if (Start) nextState = S_RUN;
        S_ERROR: ;
        default: nextState = S_IDLE;
      endcase
    end
  end

  assign Done      = !Reset && (state == S_HALTED);
  assign Error     = !Reset && (state == S_ERROR);
  assign InstCount = Reset ? '0 : count;
endmodule

// File: tb/tb_acc_ctrl_seq.sv
// Self-checking bench for acc_ctrl_seq: decode vector table, hand-written
// multi-cycle sequences and randomized traffic against a rule-level model.
module tb_acc_ctrl_seq;
  localparam int unsigned TO = 15;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic [3:0]  ReadAddr, RegWriteAddr;
  logic        ReadRegEn, WriteRegEn, WriteACCEn, Done, Error;
  logic [1:0]  ACCSel;
  logic [2:0]  ALUOp;
  logic [15:0] InstCount;

  acc_ctrl_seq_if bus();

  acc_ctrl_seq #(.RAW(4), .MEM_TIMEOUT(TO), .ACC_IDX(4'b1110)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .bus(bus),
    .ReadAddr(ReadAddr), .ReadRegEn(ReadRegEn), .RegWriteAddr(RegWriteAddr),
    .WriteRegEn(WriteRegEn), .WriteACCEn(WriteACCEn), .ACCSel(ACCSel),
    .ALUOp(ALUOp), .Done(Done), .Error(Error), .InstCount(InstCount)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       ready;
    logic [3:0] rAddr;
    logic       rEn;
    logic [3:0] wAddr;
    logic       wEn;
    logic       accEn;
    logic [1:0] accSel;
    logic [2:0] aluOp;
    logic       memReq;
    logic       memWr;
  } outs_t;

  typedef struct {
    logic       valid;
    logic [8:0] inst;
    outs_t      exp;
    outs_t      care;
  } vec_t;

  typedef enum {M_IDLE, M_RUN, M_WAIT, M_HALT, M_ERR} mode_e;

  int errors = 0;
  int checks = 0;
  int expCount;
  vec_t vec[13];

  mode_e      mMode;
  int         mCount;
  int         mMisses;
  logic       mIsStore, mR;
  logic [3:0] mOpnd;

  function automatic outs_t mkOuts(input logic ready, input logic [3:0] rAddr, input logic rEn,
                                   input logic [3:0] wAddr, input logic wEn, input logic accEn,
                                   input logic [1:0] accSel, input logic [2:0] aluOp,
                                   input logic memReq, input logic memWr);
    outs_t o;
    o.ready = ready; o.rAddr = rAddr; o.rEn = rEn; o.wAddr = wAddr; o.wEn = wEn;
    o.accEn = accEn; o.accSel = accSel; o.aluOp = aluOp; o.memReq = memReq; o.memWr = memWr;
    return o;
  endfunction

  // Ready and every enable are always compared; the flags pick which value fields matter.
  function automatic outs_t careMask(input logic addrs, input logic wa, input logic sel, input logic alu);
    return mkOuts(1'b1, addrs ? 4'hF : 4'h0, 1'b1, wa ? 4'hF : 4'h0, 1'b1, 1'b1,
                  sel ? 2'b11 : 2'b00, alu ? 3'b111 : 3'b000, 1'b1, 1'b1);
  endfunction

  function automatic outs_t dutOuts();
    return mkOuts(bus.InstReady, ReadAddr, ReadRegEn, RegWriteAddr, WriteRegEn, WriteACCEn,
                  ACCSel, ALUOp, bus.MemReq, bus.MemWrite);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chkOuts(input string name, input outs_t exp, input outs_t care);
    logic [19:0] av, ev, cv;
    av = dutOuts();
    ev = exp;
    cv = care;
    chk(name, {12'b0, av & cv}, {12'b0, ev & cv});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic setIn(input logic v, input logic [8:0] i, input logic ack, input logic st);
    bus.InstValid = v;
    bus.Inst      = i;
    bus.MemAck    = ack;
    Start         = st;
  endtask

  task automatic doReset();
    setIn(1'b0, 9'h0, 1'b0, 1'b0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic doStart();
    setIn(1'b0, 9'h0, 1'b0, 1'b1);
    tick();
    Start = 1'b0;
  endtask

  // Rule-level expectation for the current cycle's inputs.
  function automatic void modelExpect(input logic rst, input logic v, input logic [8:0] inst,
                                      input logic ack, output outs_t e, output outs_t c);
    logic [3:0] op, opd;
    logic       r;
    op  = inst[8:5];
    r   = inst[4];
    opd = inst[3:0];
    e = '0;
    c = careMask(1'b1, 1'b1, 1'b1, 1'b1);
    if (rst) return;
    case (mMode)
      M_RUN: begin
        e.ready = 1'b1;
        c = careMask(1'b0, 1'b0, 1'b0, 1'b0);
        if (v && !(op inside {4'hC, 4'hD, 4'hE}) && !(op == 4'h1 && !r)) begin
          e.rAddr = opd; e.rEn = r; e.wAddr = opd;
          c = careMask(1'b1, 1'b1, 1'b0, 1'b0);
          if (op == 4'h0) begin e.accEn = 1'b1; e.accSel = 2'd1; c.accSel = 2'b11; end
          if (op == 4'h1) e.wEn = (opd != 4'hE);
          if (op >= 4'h2 && op <= 4'h8) begin
            e.accEn = 1'b1; e.accSel = 2'd0; e.aluOp = 3'(op - 4'h2);
            c.accSel = 2'b11; c.aluOp = 3'b111;
          end
        end
      end
      M_WAIT: begin
        e.memReq = 1'b1; e.memWr = mIsStore; e.rAddr = mOpnd; e.rEn = mR;
        c = careMask(1'b1, 1'b0, 1'b0, 1'b0);
        if (ack && !mIsStore) begin e.accEn = 1'b1; e.accSel = 2'd2; c.accSel = 2'b11; end
      end
      M_HALT: c = careMask(1'b0, 1'b0, 1'b0, 1'b0);
      default: ;
    endcase
  endfunction

  function automatic void modelCommit(input logic rst, input logic st, input logic v,
                                      input logic [8:0] inst, input logic ack);
    logic [3:0] op;
    op = inst[8:5];
    if (rst) begin
      mMode = M_IDLE; mCount = 0; mMisses = 0;
      return;
    end
    case (mMode)
      M_IDLE: if (st) mMode = M_RUN;
      M_RUN: if (v) begin
        if ((op inside {4'hC, 4'hD, 4'hE}) || (op == 4'h1 && !inst[4])) mMode = M_ERR;
        else if (op == 4'h9 || op == 4'hA) begin
          mMode = M_WAIT; mMisses = 0; mIsStore = (op == 4'hA); mR = inst[4]; mOpnd = inst[3:0];
        end else begin
          if (mCount < 65535) mCount++;
          if (op == 4'hF) mMode = M_HALT;
        end
      end
      M_WAIT: begin
        if (ack) begin
          if (mCount < 65535) mCount++;
          mMode = M_RUN;
        end else begin
          mMisses++;
          if (mMisses == TO) mMode = M_ERR;
        end
      end
      M_HALT: if (st) begin mMode = M_RUN; mCount = 0; end
      default: ;
    endcase
  endfunction

  initial begin
    outs_t careAll, careEn, careWait, e, c;
    careAll  = careMask(1'b1, 1'b1, 1'b1, 1'b1);
    careEn   = careMask(1'b0, 1'b0, 1'b0, 1'b0);
    careWait = careMask(1'b1, 1'b0, 1'b0, 1'b0);

    vec[0]  = '{1'b1, 9'b0000_0_0101, mkOuts(1,4'd5,0,4'd5,0,1,2'd1,3'd0,0,0), careMask(1,1,1,0)};
    vec[1]  = '{1'b1, 9'b0000_1_0111, mkOuts(1,4'd7,1,4'd7,0,1,2'd1,3'd0,0,0), careMask(1,1,1,0)};
    vec[2]  = '{1'b1, 9'b0001_1_0011, mkOuts(1,4'd3,1,4'd3,1,0,2'd0,3'd0,0,0), careMask(1,1,0,0)};
    vec[3]  = '{1'b1, 9'b0010_1_0011, mkOuts(1,4'd3,1,4'd3,0,1,2'd0,3'd0,0,0), careAll};
    vec[4]  = '{1'b1, 9'b0011_0_1001, mkOuts(1,4'd9,0,4'd9,0,1,2'd0,3'd1,0,0), careAll};
    vec[5]  = '{1'b1, 9'b0100_1_0001, mkOuts(1,4'd1,1,4'd1,0,1,2'd0,3'd2,0,0), careAll};
    vec[6]  = '{1'b1, 9'b0101_0_1111, mkOuts(1,4'd15,0,4'd15,0,1,2'd0,3'd3,0,0), careAll};
    vec[7]  = '{1'b1, 9'b0110_1_0010, mkOuts(1,4'd2,1,4'd2,0,1,2'd0,3'd4,0,0), careAll};
    vec[8]  = '{1'b1, 9'b0111_0_0001, mkOuts(1,4'd1,0,4'd1,0,1,2'd0,3'd5,0,0), careAll};
    vec[9]  = '{1'b1, 9'b1000_1_0100, mkOuts(1,4'd4,1,4'd4,0,1,2'd0,3'd6,0,0), careAll};
    vec[10] = '{1'b1, 9'b0001_1_1110, mkOuts(1,4'd14,1,4'd14,0,0,2'd0,3'd0,0,0), careMask(1,1,0,0)};
    vec[11] = '{1'b1, 9'b1011_0_0000, mkOuts(1,4'd0,0,4'd0,0,0,2'd0,3'd0,0,0), careMask(1,1,0,0)};
    vec[12] = '{1'b0, 9'b0010_1_0101, mkOuts(1,4'd0,0,4'd0,0,0,2'd0,3'd0,0,0), careEn};

    // Reset held with busy inputs: everything quiet.
    Reset = 1'b1;
    setIn(1'b1, 9'b0000_0_0101, 1'b1, 1'b1);
    tick(); tick();
    @(negedge CLK);
    chkOuts("reset_outs", '0, careAll);
    chk("reset_done", Done, 0);
    chk("reset_err", Error, 0);
    chk("reset_cnt", InstCount, 0);
    tick();
    Reset = 1'b0;
    setIn(1'b1, 9'b0000_0_0101, 1'b0, 1'b0);
    @(negedge CLK);
    chkOuts("idle_ignores_inst", '0, careAll);
    tick();
    doStart();

    // Decode table in RUN.
    expCount = 0;
    for (int k = 0; k < 13; k++) begin
      setIn(vec[k].valid, vec[k].inst, 1'b0, 1'b0);
      @(negedge CLK);
      chkOuts($sformatf("vec%0d", k), vec[k].exp, vec[k].care);
      chk($sformatf("vec%0d_cnt", k), InstCount, expCount);
      tick();
      if (vec[k].valid) expCount++;
    end

    // LW R2, ack on the 4th wait cycle.
    setIn(1'b1, 9'b1001_1_0010, 1'b0, 1'b0);
    @(negedge CLK);
    chkOuts("lw_accept", mkOuts(1,4'd0,1,4'd0,0,0,2'd0,3'd0,0,0), careEn);
    tick();
    for (int w = 1; w <= 4; w++) begin
      setIn(1'b0, 9'h0, (w == 4), 1'b0);
      @(negedge CLK);
      c = careWait;
      if (w == 4) c.accSel = 2'b11;
      chkOuts($sformatf("lw_wait%0d", w), mkOuts(0,4'd2,1,4'd0,0,(w == 4),2'd2,3'd0,1,0), c);
      chk($sformatf("lw_wait%0d_cnt", w), InstCount, expCount);
      tick();
    end
    setIn(1'b0, 9'h0, 1'b0, 1'b0);
    @(negedge CLK);
    expCount++;
    chkOuts("lw_back_run", mkOuts(1,4'd0,0,4'd0,0,0,2'd0,3'd0,0,0), careEn);
    chk("lw_cnt", InstCount, expCount);

    // SW R5 with no ack: timeout after TO wait cycles.
    setIn(1'b1, 9'b1010_1_0101, 1'b0, 1'b0);
    tick();
    for (int w = 1; w <= TO; w++) begin
      setIn(1'b0, 9'h0, 1'b0, 1'b0);
      @(negedge CLK);
      chkOuts($sformatf("sw_wait%0d", w), mkOuts(0,4'd5,1,4'd0,0,0,2'd0,3'd0,1,1), careWait);
      tick();
    end
    @(negedge CLK);
    chkOuts("sw_timeout_outs", '0, careAll);
    chk("sw_timeout_err", Error, 1);
    chk("sw_timeout_cnt", InstCount, expCount);
    setIn(1'b1, 9'b0000_0_0001, 1'b0, 1'b1);
    tick();
    setIn(1'b1, 9'b0000_0_0001, 1'b0, 1'b0);
    @(negedge CLK);
    chk("err_start_ignored", Error, 1);
    chkOuts("err_outs", '0, careAll);
    doReset();
    @(negedge CLK);
    chk("err_reset_clears", Error, 0);
    chkOuts("err_reset_idle", '0, careAll);
    doStart();

    // SW again, ack in the last allowed cycle.
    expCount = 0;
    setIn(1'b1, 9'b1010_1_0101, 1'b0, 1'b0);
    tick();
    for (int w = 1; w <= TO; w++) begin
      setIn(1'b0, 9'h0, (w == TO), 1'b0);
      tick();
    end
    setIn(1'b0, 9'h0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("sw_late_ack_err", Error, 0);
    chk("sw_late_ack_ready", bus.InstReady, 1);
    chk("sw_late_ack_cnt", InstCount, 1);

    // Illegal opcode C and ST immediate.
    for (int t = 0; t < 2; t++) begin
      logic [8:0] bad;
      bad = (t == 0) ? 9'b1100_1_0011 : 9'b0001_0_0011;
      doReset();
      doStart();
      setIn(1'b1, 9'b1011_0_0000, 1'b0, 1'b0);
      tick();
      setIn(1'b1, bad, 1'b0, 1'b0);
      @(negedge CLK);
      chkOuts($sformatf("illegal%0d_outs", t), mkOuts(1,4'd0,0,4'd0,0,0,2'd0,3'd0,0,0), careEn);
      tick();
      setIn(1'b0, 9'h0, 1'b0, 1'b0);
      @(negedge CLK);
      chk($sformatf("illegal%0d_err", t), Error, 1);
      chk($sformatf("illegal%0d_cnt", t), InstCount, 1);
    end

    // HALT after three instructions, then restart.
    doReset();
    doStart();
    setIn(1'b1, 9'b0000_0_0001, 1'b0, 1'b0); tick();
    setIn(1'b1, 9'b0010_1_0001, 1'b0, 1'b0); tick();
    setIn(1'b1, 9'b1011_0_0000, 1'b0, 1'b0); tick();
    setIn(1'b1, 9'b1111_0_0000, 1'b0, 1'b0);
    @(negedge CLK);
    chk("halt_done_same_cycle", Done, 0);
    tick();
    setIn(1'b0, 9'h0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("halt_done", Done, 1);
    chk("halt_cnt", InstCount, 4);
    chkOuts("halt_outs", '0, careEn);
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    @(negedge CLK);
    chk("restart_done", Done, 0);
    chk("restart_cnt", InstCount, 0);
    chk("restart_ready", bus.InstReady, 1);

    // Reset in the middle of a load.
    setIn(1'b1, 9'b1001_1_0010, 1'b0, 1'b0);
    tick();
    setIn(1'b0, 9'h0, 1'b0, 1'b0);
    tick(); tick();
    Reset = 1'b1;
    @(negedge CLK);
    chk("midwait_reset_held_memreq", bus.MemReq, 0);
    tick();
    Reset = 1'b0;
    setIn(1'b1, 9'b0000_0_0001, 1'b0, 1'b0);
    @(negedge CLK);
    chkOuts("midwait_reset_idle", '0, careAll);
    chk("midwait_reset_cnt", InstCount, 0);
    tick();
    doStart();

    // Counter saturation.
    setIn(1'b1, 9'b1011_0_0000, 1'b0, 1'b0);
    repeat (65537) tick();
    @(negedge CLK);
    chk("cnt_saturate", InstCount, 16'hFFFF);

    // Randomized traffic against the model.
    doReset();
    mMode = M_IDLE; mCount = 0; mMisses = 0; mIsStore = 1'b0; mR = 1'b0; mOpnd = 4'h0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic       rv, rs, rr, ra;
      logic [3:0] op;
      logic [8:0] ri;
      rr = (mMode == M_ERR) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      rs = ($urandom_range(0, 9) == 0);
      rv = ($urandom_range(0, 9) < 7);
      ra = ($urandom_range(0, 4) == 0);
      op = 4'($urandom_range(0, 15));
      if (op inside {4'hC, 4'hD, 4'hE} && $urandom_range(0, 3) != 0) op = 4'hB;
      ri = {op, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
      Reset = rr;
      setIn(rv, ri, ra, rs);
      modelExpect(rr, rv, ri, ra, e, c);
      @(negedge CLK);
      chkOuts($sformatf("rand%0d_outs", cyc), e, c);
      chk($sformatf("rand%0d_done", cyc), Done, (!rr && mMode == M_HALT));
      chk($sformatf("rand%0d_err", cyc), Error, (!rr && mMode == M_ERR));
      chk($sformatf("rand%0d_cnt", cyc), InstCount, rr ? 0 : mCount);
      tick();
      modelCommit(rr, rs, rv, ri, ra);
    end
    Reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/acc_ctrl_seq.md
Name: acc_ctrl_seq

Overview:
- Decode/sequencing stage directly upstream of the accumulator register file.
- Accepts 9-bit instructions from fetch over a valid/ready handshake and decodes each into register-file controls: ReadAddr, ReadRegEn, RegWriteAddr, WriteRegEn, WriteACCEn.
- Also drives ACC-source select, ALU op and data-memory request.
- Sequences multi-cycle loads/stores with an ack timeout, tracks run/halt/error state, and counts retired instructions.

Parameters:
- RAW, 4, register-file address width; equals the instruction operand field width.
- MEM_TIMEOUT, 15, max MEM_WAIT cycles without MemAck before ERROR (>=1).
- ACC_IDX, 4'b1110, accumulator register index.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  start/restart pulse.
- InstValid  in  1  fetch presents Inst.
- Inst  in  9  [8:5] opcode, [4] R (1=register operand, 0=immediate), [3:0] operand.
- InstReady  out  1  stage accepts Inst this cycle.
- ReadAddr  out  RAW  register-file read pointer, or immediate value.
- ReadRegEn  out  1  1 = read register; 0 = ReadAddr used as immediate.
- RegWriteAddr  out  RAW  register-file write target.
- WriteRegEn  out  1  RF[RegWriteAddr] <= ACC.
- WriteACCEn  out  1  ACC <= selected source.
- ACCSel  out  2  0 = ALU result, 1 = ReadDataOut, 2 = memory read data.
- ALUOp  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR.
- MemReq  out  1  memory access active; address = ReadDataOut.
- MemWrite  out  1  qualifies MemReq as store (data = ACC).
- MemAck  in  1  memory completes access this cycle.
- Done  out  1  halted normally.
- Error  out  1  illegal opcode or memory timeout; sticky.
- InstCount  out  16  retired instruction count.

Behaviour:
- States: IDLE, RUN, MEM_WAIT, HALTED, ERROR.
- Reset (any state, including mid-MEM_WAIT) -> IDLE, InstCount=0, Done=0, Error=0, wait counter=0. All enables, MemReq and MemWrite are 0 from the cycle after the reset edge. Outputs are 0 while Reset is held.
- IDLE: Start -> RUN. All controls 0. InstValid ignored.
- RUN: InstReady=1. Decode is combinational from Inst, and enables are qualified by InstValid; with no valid instruction all enables are 0. An accepted instruction's RF write happens on that same edge (1-cycle latency). ReadAddr=Inst[3:0], ReadRegEn=Inst[4], RegWriteAddr=Inst[3:0].
- Opcodes:
  - 0 LD: WriteACCEn=1, ACCSel=1.
  - 1 ST: WriteRegEn=1; R=0 is illegal. ST to ACC_IDX is legal, no effect.
  - 2-8 ADD/SUB/AND/OR/XOR/SHL/SHR: WriteACCEn=1, ACCSel=0, ALUOp=opcode-2.
  - 9 LW, A SW: latch R and operand, go to MEM_WAIT. No write this cycle.
  - B NOP.
  - F HALT: go to HALTED.
  - C, D, E: illegal.
- Illegal instruction -> ERROR with no enables asserted; it is not counted.
- InstCount +1 per retired instruction: every accepted legal instruction except LW/SW, which count on MemAck. HALT counts. InstCount saturates at 16'hFFFF.
- MEM_WAIT:
  - InstReady=0, MemReq=1, MemWrite=1 for SW. ReadAddr/ReadRegEn come from the latched operand.
  - MemAck: for LW, WriteACCEn=1 and ACCSel=2 in that cycle. Then return to RUN and clear the wait counter.
  - No MemAck: wait counter +1. A MEM_TIMEOUT-th consecutive cycle without ack -> ERROR. An ack arriving in that same cycle wins and is treated as a normal completion.
  - Start is ignored in MEM_WAIT.
- HALTED: Done=1 (registered, rises the cycle after HALT is accepted). Start -> RUN, Done=0, InstCount=0.
- ERROR: Error=1 (registered). All controls 0. Exit only by Reset.
- Start in RUN or ERROR is ignored.

Decomposition:
- Shared package acc_pkg:
  - opcode enum (4-bit);
  - state enum;
  - ALU-op enum (3-bit);
  - ACCSel constants;
  - ACC_IDX;
  - field-slice localparams OPC_MSB/LSB, R_BIT.
- Sub-module mem_wait_timer: counter with clear/enable/expire, parameterised by MEM_TIMEOUT.
- Decode stays inline in acc_ctrl_seq.

Test Plan:
- Reset, Start, then LD imm 0x5 (Inst=9'b0000_0_0101) -> same cycle WriteACCEn=1, ACCSel=1, ReadRegEn=0, ReadAddr=5; next cycle InstCount=1.
- ST R3 (9'b0001_1_0011) then ADD R3 (9'b0010_1_0011) -> cycle 1 WriteRegEn=1, RegWriteAddr=3; cycle 2 ALUOp=0, WriteACCEn=1, ACCSel=0; InstCount=2.
- LW R2 with MemAck after 3 wait cycles -> InstReady=0 and MemReq=1 for 4 cycles; WriteACCEn=1 and ACCSel=2 only in the ack cycle; then back to RUN; InstCount +1.
- SW with MEM_TIMEOUT=15 and no ack -> MemReq=1, MemWrite=1 for 15 cycles, then Error=1 and all controls 0. Repeat with ack in cycle 15 -> no error.
- Illegal opcode 0xC, and ST with R=0 -> ERROR with no enables asserted and InstCount unchanged; Start ignored; Reset -> IDLE, Error=0.
- HALT after 3 instructions -> Done=1, InstCount=4; Start -> RUN, Done=0, InstCount=0. Reset asserted mid-MEM_WAIT -> MemReq=0 next cycle, state IDLE.
